// File: rtl/uart_frame_check.sv
// UART RX frame checker: 3-sample majority vote, parity and stop-bit checks,
// sticky error flags and saturating error counters for the status block.
module uart_frame_check #(
    parameter int PRESCALE_W = 6,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop_bits,
    input  logic [7:0]            data_byte,
    input  logic                  par_chk_en,
    input  logic                  stp_chk_en,
    input  logic                  clr_status,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  frame_done,
    output logic [1:0]            err_sticky,
    output logic [CNT_W-1:0]      par_err_cnt,
    output logic [CNT_W-1:0]      stp_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STOP1 = 2'd1,
        ST_STOP2 = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [CNT_W-1:0]      C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      C_MAX = '1;

    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_last;
    logic                  w_eval;
    logic                  w_vote;
    logic                  w_par_err_nxt;
    logic                  w_stp_err_nxt;
    logic                  w_done_nxt;
    logic [2:0]            r_samp;
    state_t                r_state;
    state_t                w_state_nxt;

    assign w_mid  = {1'b0, prescale[PRESCALE_W-1:1]};
    assign w_last = prescale - P_ONE;
    assign w_eval = (edge_cnt == w_last);
    assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

    // Samples around the bit centre are captured regardless of which bit is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_samp <= 3'b000;
        end else begin
            if (edge_cnt == w_mid - P_ONE) r_samp[0] <= rx_in;
            if (edge_cnt == w_mid)         r_samp[1] <= rx_in;
            if (edge_cnt == w_mid + P_ONE) r_samp[2] <= rx_in;
        end
    end

    assign w_par_err_nxt = w_eval && par_chk_en && par_en &&
                           (((^data_byte) ^ par_type) != w_vote);

    always_comb begin
        w_state_nxt   = r_state;
        w_stp_err_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stp_chk_en) w_state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (!stp_chk_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_eval) begin
                    w_stp_err_nxt = ~w_vote;
                    if (stop_bits) begin
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (!stp_chk_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_eval) begin
                    w_stp_err_nxt = ~w_vote;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            par_err    <= w_par_err_nxt;
            stp_err    <= w_stp_err_nxt;
            frame_done <= w_done_nxt;
        end
    end

    // A clear coinciding with a new error keeps that error as the first event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky  <= 2'b00;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (clr_status) begin
            err_sticky  <= {w_stp_err_nxt, w_par_err_nxt};
            par_err_cnt <= w_par_err_nxt ? C_ONE : '0;
            stp_err_cnt <= w_stp_err_nxt ? C_ONE : '0;
        end else begin
            err_sticky <= err_sticky | {w_stp_err_nxt, w_par_err_nxt};
            if (w_par_err_nxt && (par_err_cnt != C_MAX)) par_err_cnt <= par_err_cnt + C_ONE;
            if (w_stp_err_nxt && (stp_err_cnt != C_MAX)) stp_err_cnt <= stp_err_cnt + C_ONE;
        end
    end

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: directed frames plus randomized frames checked
// against a frame-level reference model of parity, stop and status rules.
module tb_uart_frame_check;

    localparam int PW   = 6;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_cnt;
    logic          rx_in;
    logic          par_en;
    logic          par_type;
    logic          stop_bits;
    logic [7:0]    data_byte;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          clr_status;
    logic          par_err;
    logic          stp_err;
    logic          frame_done;
    logic [1:0]    err_sticky;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stp_err_cnt;

    always #5 clk = ~clk;

    uart_frame_check #(.PRESCALE_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .edge_cnt(edge_cnt), .rx_in(rx_in),
        .par_en(par_en), .par_type(par_type), .stop_bits(stop_bits), .data_byte(data_byte),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .clr_status(clr_status),
        .par_err(par_err), .stp_err(stp_err), .frame_done(frame_done),
        .err_sticky(err_sticky), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         ps;
    logic [1:0] m_sticky;
    int         m_pc;
    int         m_sc;
    logic       obs_p, obs_s, obs_d;
    int         obs_spur;
    logic       fo_p[3], fo_s[3], fo_d[3];
    logic       fe_p[3], fe_s[3], fe_d[3];

    function automatic logic vote_of(input logic b, input logic [2:0] m);
        return $countones({3{b}} ^ m) >= 2;
    endfunction

    task automatic model_reset();
        m_sticky = 2'b00;
        m_pc     = 0;
        m_sc     = 0;
    endtask

    task automatic model_update(input logic p, input logic s, input logic c);
        if (c) begin
            m_sticky = {s, p};
            m_pc     = p ? 1 : 0;
            m_sc     = s ? 1 : 0;
        end else begin
            m_sticky = m_sticky | {s, p};
            if (p && m_pc < CMAX) m_pc++;
            if (s && m_sc < CMAX) m_sc++;
        end
    endtask

    // One bit period; mask flips the three centre samples, other edges get random noise.
    task automatic drive_period(input logic base, input logic [2:0] mask, input logic pchk,
                                input logic schk, input int drop_at, input int clr_at,
                                input logic ep, input logic es);
        int   mid;
        logic r;
        mid = ps / 2;
        for (int e = 0; e < ps; e++) begin
            if (e >= mid - 1 && e <= mid + 1) r = base ^ mask[e - mid + 1];
            else r = ($urandom_range(0, 3) == 0) ? ~base : base;
            @(negedge clk);
            edge_cnt   = PW'(e);
            rx_in      = r;
            par_chk_en = pchk;
            stp_chk_en = (drop_at >= 0 && e >= drop_at) ? 1'b0 : schk;
            clr_status = (e == clr_at);
            @(posedge clk);
            #1;
            if (e == ps - 1) begin
                model_update(ep, es, clr_status);
                obs_p = par_err;
                obs_s = stp_err;
                obs_d = frame_done;
            end else begin
                model_update(1'b0, 1'b0, clr_status);
                if (par_err || stp_err || frame_done) obs_spur++;
            end
        end
    endtask

    task automatic drive_idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            edge_cnt   = '0;
            rx_in      = 1'($urandom_range(0, 1));
            par_chk_en = 1'b0;
            stp_chk_en = 1'b0;
            clr_status = clr;
            @(posedge clk);
            #1;
            model_update(1'b0, 1'b0, clr);
            if (par_err || stp_err || frame_done) obs_spur++;
        end
        clr_status = 1'b0;
    endtask

    // Parity period (par_chk_en always asserted), one or two stop periods, one idle cycle.
    task automatic drive_frame(input logic [7:0] data, input logic pbit, input logic [2:0] pm,
                               input logic s1, input logic [2:0] m1, input logic s2,
                               input logic [2:0] m2, input int clr_at);
        for (int i = 0; i < 3; i++) begin
            fo_p[i] = 1'b0; fo_s[i] = 1'b0; fo_d[i] = 1'b0;
            fe_p[i] = 1'b0; fe_s[i] = 1'b0; fe_d[i] = 1'b0;
        end
        obs_spur  = 0;
        data_byte = data;
        fe_p[0] = par_en && (((^data) ^ par_type) != vote_of(pbit, pm));
        drive_period(pbit, pm, 1'b1, 1'b0, -1, -1, fe_p[0], 1'b0);
        fo_p[0] = obs_p; fo_s[0] = obs_s; fo_d[0] = obs_d;
        fe_s[1] = ~vote_of(s1, m1);
        fe_d[1] = ~stop_bits;
        drive_period(s1, m1, 1'b0, 1'b1, -1, stop_bits ? -1 : clr_at, 1'b0, fe_s[1]);
        fo_p[1] = obs_p; fo_s[1] = obs_s; fo_d[1] = obs_d;
        if (stop_bits) begin
            fe_s[2] = ~vote_of(s2, m2);
            fe_d[2] = 1'b1;
            drive_period(s2, m2, 1'b0, 1'b1, -1, clr_at, 1'b0, fe_s[2]);
            fo_p[2] = obs_p; fo_s[2] = obs_s; fo_d[2] = obs_d;
        end
        drive_idle(1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; ps = 8; prescale = 8'd8; edge_cnt = '0; rx_in = 1'b1;
        par_en = 1'b0; par_type = 1'b0; stop_bits = 1'b0; data_byte = '0;
        par_chk_en = 1'b0; stp_chk_en = 1'b0; clr_status = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (par_err !== 1'b0) $display("FAIL reset_par_err got %b want 0", par_err); else n_pass++;
        n_checks++; if (stp_err !== 1'b0) $display("FAIL reset_stp_err got %b want 0", stp_err); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
        n_checks++; if (err_sticky !== 2'b00) $display("FAIL reset_sticky got %b want 00", err_sticky); else n_pass++;
        n_checks++; if (par_err_cnt !== '0) $display("FAIL reset_par_cnt got %0d want 0", par_err_cnt); else n_pass++;
        n_checks++; if (stp_err_cnt !== '0) $display("FAIL reset_stp_cnt got %0d want 0", stp_err_cnt); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_spec_vectors();
        ps = 8; prescale = 6'd8; par_en = 1'b1; par_type = 1'b0; stop_bits = 1'b0;
        drive_frame(8'hA5, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 3'b000, -1);
        n_checks++; if (fo_p[0] !== 1'b0) $display("FAIL even_par_err got %b want 0", fo_p[0]); else n_pass++;
        n_checks++; if (fo_s[1] !== 1'b0) $display("FAIL even_stp_err got %b want 0", fo_s[1]); else n_pass++;
        n_checks++; if (fo_d[1] !== 1'b1) $display("FAIL even_frame_done got %b want 1", fo_d[1]); else n_pass++;
        n_checks++; if (obs_spur !== 0) $display("FAIL even_stray_pulses got %0d want 0", obs_spur); else n_pass++;

        par_type = 1'b1;
        drive_frame(8'hA5, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 3'b000, -1);
        n_checks++; if (fo_p[0] !== 1'b1) $display("FAIL odd_par_err got %b want 1", fo_p[0]); else n_pass++;
        n_checks++; if (err_sticky !== 2'b01) $display("FAIL odd_sticky got %b want 01", err_sticky); else n_pass++;
        n_checks++; if (par_err_cnt !== 2'd1) $display("FAIL odd_par_cnt got %0d want 1", par_err_cnt); else n_pass++;
        n_checks++; if (stp_err_cnt !== 2'd0) $display("FAIL odd_stp_cnt got %0d want 0", stp_err_cnt); else n_pass++;

        ps = 16; prescale = 6'd16; par_type = 1'b0; stop_bits = 1'b1;
        drive_frame(8'hA5, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000, -1);
        n_checks++; if (fo_s[1] !== 1'b0) $display("FAIL two_stop1_err got %b want 0", fo_s[1]); else n_pass++;
        n_checks++; if (fo_d[1] !== 1'b0) $display("FAIL two_stop1_done got %b want 0", fo_d[1]); else n_pass++;
        n_checks++; if (fo_s[2] !== 1'b1) $display("FAIL two_stop2_err got %b want 1", fo_s[2]); else n_pass++;
        n_checks++; if (fo_d[2] !== 1'b1) $display("FAIL two_stop2_done got %b want 1", fo_d[2]); else n_pass++;
        n_checks++; if (stp_err_cnt !== 2'd1) $display("FAIL two_stp_cnt got %0d want 1", stp_err_cnt); else n_pass++;
        n_checks++; if (err_sticky !== 2'b11) $display("FAIL two_sticky got %b want 11", err_sticky); else n_pass++;
        n_checks++; if (obs_spur !== 0) $display("FAIL two_stray_pulses got %0d want 0", obs_spur); else n_pass++;

        ps = 8; prescale = 6'd8; stop_bits = 1'b0;
        drive_frame(8'hA5, 1'b0, 3'b001, 1'b1, 3'b010, 1'b1, 3'b000, -1);
        n_checks++; if (fo_p[0] !== 1'b0) $display("FAIL glitch_par_err got %b want 0", fo_p[0]); else n_pass++;
        n_checks++; if (fo_s[1] !== 1'b0) $display("FAIL glitch_stp_err got %b want 0", fo_s[1]); else n_pass++;
        n_checks++; if (fo_d[1] !== 1'b1) $display("FAIL glitch_done got %b want 1", fo_d[1]); else n_pass++;

        drive_frame(8'hA5, 1'b0, 3'b000, 1'b1, 3'b011, 1'b1, 3'b000, -1);
        n_checks++; if (fo_s[1] !== 1'b1) $display("FAIL outvoted_stp_err got %b want 1", fo_s[1]); else n_pass++;
        n_checks++; if (stp_err_cnt !== 2'd2) $display("FAIL outvoted_stp_cnt got %0d want 2", stp_err_cnt); else n_pass++;

        drive_idle(1, 1'b1);
        n_checks++; if (err_sticky !== 2'b00) $display("FAIL clear_sticky got %b want 00", err_sticky); else n_pass++;
        n_checks++; if (par_err_cnt !== 2'd0) $display("FAIL clear_par_cnt got %0d want 0", par_err_cnt); else n_pass++;
        n_checks++; if (stp_err_cnt !== 2'd0) $display("FAIL clear_stp_cnt got %0d want 0", stp_err_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        int want;
        ps = 8; prescale = 6'd8; par_en = 1'b1; par_type = 1'b1; stop_bits = 1'b0;
        for (int k = 0; k < 5; k++) begin
            want = (k + 1 > CMAX) ? CMAX : k + 1;
            drive_frame(8'hA5, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000, -1);
            n_checks++; if (stp_err_cnt !== CW'(want)) $display("FAIL sat_stp_cnt[%0d] got %0d want %0d", k, stp_err_cnt, want); else n_pass++;
            n_checks++; if (par_err_cnt !== CW'(want)) $display("FAIL sat_par_cnt[%0d] got %0d want %0d", k, par_err_cnt, want); else n_pass++;
        end
        par_type = 1'b0;
        drive_frame(8'hA5, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000, ps - 1);
        n_checks++; if (fo_s[1] !== 1'b1) $display("FAIL clr_err_stp_err got %b want 1", fo_s[1]); else n_pass++;
        n_checks++; if (err_sticky !== 2'b10) $display("FAIL clr_err_sticky got %b want 10", err_sticky); else n_pass++;
        n_checks++; if (stp_err_cnt !== 2'd1) $display("FAIL clr_err_stp_cnt got %0d want 1", stp_err_cnt); else n_pass++;
        n_checks++; if (par_err_cnt !== 2'd0) $display("FAIL clr_err_par_cnt got %0d want 0", par_err_cnt); else n_pass++;
    endtask

    task automatic test_abort();
        ps = 8; prescale = 6'd8; par_en = 1'b0; stop_bits = 1'b0;
        drive_idle(1, 1'b1);
        obs_spur = 0;
        drive_period(1'b0, 3'b000, 1'b0, 1'b1, ps / 2 + 2, -1, 1'b0, 1'b0);
        drive_idle(1, 1'b0);
        n_checks++; if (obs_s !== 1'b0) $display("FAIL abort_stp_err got %b want 0", obs_s); else n_pass++;
        n_checks++; if (obs_d !== 1'b0) $display("FAIL abort_done got %b want 0", obs_d); else n_pass++;
        n_checks++; if (obs_spur !== 0) $display("FAIL abort_stray_pulses got %0d want 0", obs_spur); else n_pass++;
        n_checks++; if (stp_err_cnt !== 2'd0) $display("FAIL abort_stp_cnt got %0d want 0", stp_err_cnt); else n_pass++;
        stop_bits = 1'b1;
        drive_frame(8'h3C, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 3'b000, -1);
        n_checks++; if (fo_d[2] !== 1'b1) $display("FAIL after_abort_done got %b want 1", fo_d[2]); else n_pass++;
        n_checks++; if (fo_s[1] !== 1'b0 || fo_s[2] !== 1'b0) $display("FAIL after_abort_stp_err got %b%b want 00", fo_s[1], fo_s[2]); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        ps = 16; prescale = 6'd16; par_en = 1'b1; par_type = 1'b1; stop_bits = 1'b1;
        data_byte = 8'hA5;
        drive_period(1'b0, 3'b000, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0);
        drive_period(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 1'b0, 1'b1);
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            edge_cnt = PW'(e); rx_in = 1'b1; par_chk_en = 1'b0; stp_chk_en = 1'b1;
        end
        @(negedge clk);
        #1;
        n_checks++; if (err_sticky !== m_sticky) $display("FAIL pre_reset_sticky got %b want %b", err_sticky, m_sticky); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (err_sticky !== 2'b00) $display("FAIL async_reset_sticky got %b want 00", err_sticky); else n_pass++;
        n_checks++; if (par_err_cnt !== '0) $display("FAIL async_reset_par_cnt got %0d want 0", par_err_cnt); else n_pass++;
        n_checks++; if (stp_err_cnt !== '0) $display("FAIL async_reset_stp_cnt got %0d want 0", stp_err_cnt); else n_pass++;
        n_checks++; if ({par_err, stp_err, frame_done} !== 3'b000) $display("FAIL async_reset_pulses got %b want 000", {par_err, stp_err, frame_done}); else n_pass++;
        model_reset();
        stp_chk_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        par_type = 1'b0;
        drive_frame(8'hA5, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 3'b000, -1);
        n_checks++; if (fo_d[2] !== 1'b1) $display("FAIL post_reset_done got %b want 1", fo_d[2]); else n_pass++;
        n_checks++; if (err_sticky !== 2'b00) $display("FAIL post_reset_sticky got %b want 00", err_sticky); else n_pass++;
        n_checks++; if (obs_spur !== 0) $display("FAIL post_reset_stray got %0d want 0", obs_spur); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] data;
        int         clr_at;
        int         nper;
        for (int f = 0; f < 40; f++) begin
            ps        = 2 * $urandom_range(4, 31);
            prescale  = PW'(ps);
            par_en    = 1'($urandom_range(0, 1));
            par_type  = 1'($urandom_range(0, 1));
            stop_bits = 1'($urandom_range(0, 1));
            data      = 8'($urandom);
            clr_at    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ps - 1) : -1;
            drive_frame(data, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), clr_at);
            nper = stop_bits ? 3 : 2;
            for (int i = 0; i < nper; i++) begin
                n_checks++; if (fo_p[i] !== fe_p[i]) $display("FAIL rnd%0d_par_err[%0d] got %b want %b", f, i, fo_p[i], fe_p[i]); else n_pass++;
                n_checks++; if (fo_s[i] !== fe_s[i]) $display("FAIL rnd%0d_stp_err[%0d] got %b want %b", f, i, fo_s[i], fe_s[i]); else n_pass++;
                n_checks++; if (fo_d[i] !== fe_d[i]) $display("FAIL rnd%0d_done[%0d] got %b want %b", f, i, fo_d[i], fe_d[i]); else n_pass++;
            end
            n_checks++; if (obs_spur !== 0) $display("FAIL rnd%0d_stray_pulses got %0d want 0", f, obs_spur); else n_pass++;
            n_checks++; if (err_sticky !== m_sticky) $display("FAIL rnd%0d_sticky got %b want %b", f, err_sticky, m_sticky); else n_pass++;
            n_checks++; if (par_err_cnt !== CW'(m_pc)) $display("FAIL rnd%0d_par_cnt got %0d want %0d", f, par_err_cnt, m_pc); else n_pass++;
            n_checks++; if (stp_err_cnt !== CW'(m_sc)) $display("FAIL rnd%0d_stp_cnt got %0d want %0d", f, stp_err_cnt, m_sc); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_saturation();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
